// File: rtl/instr_lane_feeder_pkg.sv
// rtl/instr_lane_feeder_pkg.sv - shared SoftMC defaults, opcode field offsets and lane type
package instr_lane_feeder_pkg;

  // SoftMC instruction word defaults
  localparam int INSTR_WIDTH_DEF = 32;
  localparam int DEPTH_LOG2_DEF  = 4;

  // Opcode field location inside a SoftMC instruction word
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;

  // Lane that receives the next accepted word
  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

endpackage

// File: rtl/instr_lane_fifo.sv
// rtl/instr_lane_fifo.sv - synchronous first-word-fall-through FIFO for one instruction lane
module instr_lane_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_clear;

  assign w_clear = rst | flush;
  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  // Over/underflow requests are dropped here so callers need not gate them
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  // Head is shown directly; an empty lane reads as zero
  assign rdata   = empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; no reset needed since occupancy masks stale entries
  always_ff @(posedge clk) begin
    if (w_push & ~w_clear) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy update; clear wins over push and pop
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_lane_feeder.sv
// rtl/instr_lane_feeder.sv - splits one instruction stream into two lanes; INSTR_FEEDER_STATS_EN adds counters
module instr_lane_feeder
  import instr_lane_feeder_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic                   in_last,
  input  logic                   flush,
  output logic                   en_out0,
  input  logic                   en_ack0,
  output logic [INSTR_WIDTH-1:0] instr_out0,
  output logic                   en_out1,
  input  logic                   en_ack1,
  output logic [INSTR_WIDTH-1:0] instr_out1,
  output logic                   busy
`ifdef INSTR_FEEDER_STATS_EN
  ,
  output logic [31:0]            accepted_cnt,
  output logic [31:0]            issued_cnt
`endif
);

  lane_e               r_wr_lane;
  logic                w_full0;
  logic                w_full1;
  logic                w_empty0;
  logic                w_empty1;
  logic [DEPTH_LOG2:0] w_cnt0;
  logic [DEPTH_LOG2:0] w_cnt1;
  logic                w_unused_cnt;
  logic                w_sel_full;
  logic                w_push;
  logic                w_push0;
  logic                w_push1;
  logic                w_pop0;
  logic                w_pop1;

  // Ready looks only at the target lane; flush keeps it high so the word is dropped cleanly
  assign w_sel_full = (r_wr_lane == LANE1) ? w_full1 : w_full0;
  assign in_ready   = ~w_sel_full | flush;
  assign w_push     = in_valid & in_ready & ~flush;
  assign w_push0    = w_push & (r_wr_lane == LANE0);
  assign w_push1    = w_push & (r_wr_lane == LANE1);

  // Dispatcher may hold ack high while idle, so pops are qualified by lane valid
  assign en_out0    = ~w_empty0;
  assign en_out1    = ~w_empty1;
  assign w_pop0     = en_ack0 & en_out0 & ~flush;
  assign w_pop1     = en_ack1 & en_out1 & ~flush;
  assign busy       = en_out0 | en_out1;

  assign w_unused_cnt = ^{w_cnt0, w_cnt1};

  instr_lane_fifo #(
    .WIDTH      (INSTR_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_lane0 (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push0),
    .pop   (w_pop0),
    .flush (flush),
    .wdata (in_instr),
    .rdata (instr_out0),
    .full  (w_full0),
    .empty (w_empty0),
    .count (w_cnt0)
  );

  instr_lane_fifo #(
    .WIDTH      (INSTR_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_lane1 (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push1),
    .pop   (w_pop1),
    .flush (flush),
    .wdata (in_instr),
    .rdata (instr_out1),
    .full  (w_full1),
    .empty (w_empty1),
    .count (w_cnt1)
  );

  // Steering: alternate per accepted word, restart at lane0 after a program's last word
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      r_wr_lane <= LANE0;
    end else if (w_push) begin
      if (in_last) begin
        r_wr_lane <= LANE0;
      end else begin
        r_wr_lane <= (r_wr_lane == LANE0) ? LANE1 : LANE0;
      end
    end
  end

`ifdef INSTR_FEEDER_STATS_EN
  logic [31:0] r_accepted_cnt;
  logic [31:0] r_issued_cnt;

  assign accepted_cnt = r_accepted_cnt;
  assign issued_cnt   = r_issued_cnt;

  // Lifetime counters survive flush; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_accepted_cnt <= '0;
      r_issued_cnt   <= '0;
    end else begin
      r_accepted_cnt <= r_accepted_cnt + 32'(w_push);
      r_issued_cnt   <= r_issued_cnt + 32'(w_pop0) + 32'(w_pop1);
    end
  end
`else
  // No statistics registers in this build
`endif

endmodule

// File: tb/tb_instr_lane_feeder.sv
// tb/tb_instr_lane_feeder.sv - randomized and directed bench against a queue-based lane model
module tb_instr_lane_feeder;
  import instr_lane_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        in_last = 1'b0;
  logic        flush = 1'b0;
  logic        en_out0;
  logic        en_ack0 = 1'b0;
  logic [31:0] instr_out0;
  logic        en_out1;
  logic        en_ack1 = 1'b0;
  logic [31:0] instr_out1;
  logic        busy;
`ifdef INSTR_FEEDER_STATS_EN
  logic [31:0] accepted_cnt;
  logic [31:0] issued_cnt;
`endif

  instr_lane_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_last    (in_last),
    .flush      (flush),
    .en_out0    (en_out0),
    .en_ack0    (en_ack0),
    .instr_out0 (instr_out0),
    .en_out1    (en_out1),
    .en_ack1    (en_ack1),
    .instr_out1 (instr_out1),
    .busy       (busy)
`ifdef INSTR_FEEDER_STATS_EN
    ,
    .accepted_cnt (accepted_cnt),
    .issued_cnt   (issued_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;

  // Reference model: one queue per lane plus the steering bit and lifetime counts
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          m_wr = 1'b0;
  int unsigned m_acc = 0;
  int unsigned m_iss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int unsigned op, input int unsigned tag);
    logic [31:0] w;
    w = tag;
    w[OPCODE_MSB:OPCODE_LSB] = op[3:0];
    return w;
  endfunction

  // One clock: drive inputs, compare against the model, then advance the model
  task automatic step(input bit r, input bit v, input logic [31:0] d, input bit l,
                      input bit f, input bit a0, input bit a1);
    bit rdy;
    bit p0;
    bit p1;
    bit pu;
    @(negedge clk);
    rst = r; in_valid = v; in_instr = d; in_last = l; flush = f;
    en_ack0 = a0; en_ack1 = a1;
    #1;
    rdy = f || (m_wr ? (q1.size() < 16) : (q0.size() < 16));
    check_eq("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    check_eq("en_out0", {31'b0, en_out0}, {31'b0, q0.size() != 0});
    check_eq("en_out1", {31'b0, en_out1}, {31'b0, q1.size() != 0});
    check_eq("instr_out0", instr_out0, (q0.size() != 0) ? q0[0] : 32'h0);
    check_eq("instr_out1", instr_out1, (q1.size() != 0) ? q1[0] : 32'h0);
    check_eq("busy", {31'b0, busy}, {31'b0, (q0.size() + q1.size()) != 0});
`ifdef INSTR_FEEDER_STATS_EN
    check_eq("accepted_cnt", accepted_cnt, m_acc);
    check_eq("issued_cnt", issued_cnt, m_iss);
`endif
    p0 = a0 && (q0.size() != 0);
    p1 = a1 && (q1.size() != 0);
    pu = v && rdy;
    @(posedge clk);
    if (r || f) begin
      q0.delete();
      q1.delete();
      m_wr = 1'b0;
      if (r) begin
        m_acc = 0;
        m_iss = 0;
      end
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      m_iss += int'(p0) + int'(p1);
      if (pu) begin
        if (m_wr) q1.push_back(d); else q0.push_back(d);
        m_acc++;
        m_wr = l ? 1'b0 : ~m_wr;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] d, input bit l);
    step(1'b0, 1'b1, d, l, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] acc_snap;
    logic [31:0] iss_snap;
    int          bias;

    // Reset state, then alternating steering of six words
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) push(mk(4'hA, i), 1'b0);
    #1;
    check_eq("t1_en_out0", {31'b0, en_out0}, 32'd1);
    check_eq("t1_en_out1", {31'b0, en_out1}, 32'd1);
    check_eq("t1_busy", {31'b0, busy}, 32'd1);
    check_eq("t1_head0", instr_out0, mk(4'hA, 0));
    check_eq("t1_head1", instr_out1, mk(4'hA, 1));
    drain();

    // in_last restarts steering at lane0
    do_reset();
    push(mk(4'hC, 0), 1'b0);
    push(mk(4'hC, 1), 1'b0);
    push(mk(4'hC, 2), 1'b1);
    push(mk(4'hB, 0), 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check_eq("t2_b0_lane0", instr_out0, mk(4'hB, 0));
    push(mk(4'hD, 0), 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("t2_d0_lane1", instr_out1, mk(4'hD, 0));
    drain();

    // Full lane0 blocks input until a pop frees a slot
    do_reset();
    for (int i = 0; i < 32; i++) push(mk(4'h3, i), 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("t3_full_rdy", {31'b0, in_ready}, 32'd0);
    step(1'b0, 1'b1, mk(4'h3, 99), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check_eq("t3_after_pop_rdy", {31'b0, in_ready}, 32'd1);
    drain();

    // Push and pop on a one-entry lane1 in the same cycle
    do_reset();
    push(mk(4'h4, 0), 1'b0);
    push(mk(4'h4, 1), 1'b0);
    push(mk(4'h4, 2), 1'b0);
    step(1'b0, 1'b1, mk(4'h4, 3), 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("t4_new_head", instr_out1, mk(4'h4, 3));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("t4_occ_one", {31'b0, en_out1}, 32'd0);
    drain();

    // Acks held on empty lanes
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check_eq("t5_busy", {31'b0, busy}, 32'd0);

    // Flush wins over push and pop; counters survive it
    do_reset();
    for (int i = 0; i < 8; i++) push(mk(4'h6, i), 1'b0);
    acc_snap = m_acc;
    iss_snap = m_iss;
    step(1'b0, 1'b1, mk(4'h6, 50), 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    check_eq("t6_en_out0", {31'b0, en_out0}, 32'd0);
    check_eq("t6_en_out1", {31'b0, en_out1}, 32'd0);
`ifdef INSTR_FEEDER_STATS_EN
    check_eq("t6_acc_kept", accepted_cnt, acc_snap);
    check_eq("t6_iss_kept", issued_cnt, iss_snap);
`else
    acc_snap = iss_snap;
`endif
    push(mk(4'h6, 51), 1'b0);
    #1;
    check_eq("t6_lane0_first", {31'b0, en_out0}, 32'd1);
    check_eq("t6_lane1_empty", {31'b0, en_out1}, 32'd0);
    drain();

    // Randomized traffic with varying ack pressure, sparse last/flush/reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bias = (i / 500) % 5;
      step(($urandom % 300) == 0,
           ($urandom % 4) != 0,
           $urandom,
           ($urandom % 8) == 0,
           ($urandom % 80) == 0,
           ($urandom % 4) < bias,
           ($urandom % 4) < (4 - bias));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
